// File: rtl/pe_acc.sv
// Accumulation stage for one processing element: sums k_len products per job
// into a saturating accumulator and returns the result over valid/ready.
module pe_acc #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned K_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_start,
  input  logic [K_W-1:0]   k_len,
  input  logic             prod_vld,
  input  logic [15:0]      prod_data,
  output logic             pe_en,
  output logic             acc_busy,
  output logic             sum_vld,
  output logic [ACC_W-1:0] sum_data,
  output logic             sum_ovf,
  input  logic             sum_rdy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [K_W-1:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pe_en_q, busy_q, vld_q;
  logic [ACC_W:0]   sum_w;

  // Next-state, accumulate and saturate; the adder carry-out flags overflow.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_w   = {1'b0, acc_q} + (ACC_W + 1)'(prod_data);
    case (state_q)
      S_IDLE: begin
        if (acc_start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = k_len;
          state_d = (k_len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (prod_vld) begin
          cnt_d = cnt_q - K_W'(1);
          if (sum_w[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_w[ACC_W-1:0];
          end
          if (cnt_q == K_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (sum_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pe_en_q <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pe_en_q <= (state_d == S_ACC);
      busy_q  <= (state_d != S_IDLE);
      vld_q   <= (state_d == S_DONE);
    end
  end

  assign pe_en    = pe_en_q;
  assign acc_busy = busy_q;
  assign sum_vld  = vld_q;
  assign sum_data = acc_q;
  assign sum_ovf  = ovf_q;

endmodule

// File: tb/tb_pe_acc.sv
// Scoreboard bench for pe_acc: stimulus pushes expected sums, a monitor pops
// and compares on each sum handshake.
module tb_pe_acc;

  localparam int unsigned ACC_W = 20;
  localparam int unsigned K_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             acc_start;
  logic [K_W-1:0]   k_len;
  logic             prod_vld;
  logic [15:0]      prod_data;
  logic             pe_en;
  logic             acc_busy;
  logic             sum_vld;
  logic [ACC_W-1:0] sum_data;
  logic             sum_ovf;
  logic             sum_rdy;

  pe_acc #(.ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .acc_start(acc_start), .k_len(k_len),
    .prod_vld(prod_vld), .prod_data(prod_data), .pe_en(pe_en),
    .acc_busy(acc_busy), .sum_vld(sum_vld), .sum_data(sum_data),
    .sum_ovf(sum_ovf), .sum_rdy(sum_rdy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [ACC_W:0] sb_q[$];
  int pe_cycles = 0;
  int vld_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: count enable/valid cycles, check hold under backpressure, pop on handshake.
  logic             held_v = 1'b0;
  logic [ACC_W-1:0] held_d;
  logic             held_o;
  always @(negedge clk) begin
    logic [ACC_W:0] e;
    if (pe_en) pe_cycles++;
    if (sum_vld) vld_cycles++;
    if (sum_vld && held_v) begin
      chk("hold_data", 32'(sum_data), 32'(held_d));
      chk("hold_ovf", 32'(sum_ovf), 32'(held_o));
    end
    if (sum_vld && sum_rdy) begin
      held_v = 1'b0;
      if (sb_q.size() == 0) begin
        chk("unexpected_sum", 32'(sum_vld), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sum_data", 32'(sum_data), 32'(e[ACC_W-1:0]));
        chk("sum_ovf", 32'(sum_ovf), 32'(e[ACC_W]));
      end
    end else if (sum_vld) begin
      held_v = 1'b1;
      held_d = sum_data;
      held_o = sum_ovf;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int k);
    acc_start = 1'b1;
    k_len = K_W'(k);
    tick();
    acc_start = 1'b0;
    k_len = '0;
  endtask

  task automatic send(input int d);
    prod_vld = 1'b1;
    prod_data = 16'(d);
    tick();
    prod_vld = 1'b0;
    prod_data = '0;
  endtask

  task automatic expect_sum(input int s, input bit o);
    sb_q.push_back({o, ACC_W'(s)});
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!acc_busy) break;
      tick();
    end
    chk(name, 32'(acc_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pe0, vld0;
    rst_n = 1'b0; sum_rdy = 1'b0; acc_start = 1'b0; k_len = '0;
    prod_vld = 1'b0; prod_data = '0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      acc_start = 1'($urandom); k_len = K_W'($urandom);
      prod_vld = 1'($urandom); prod_data = 16'($urandom);
      sum_rdy = 1'($urandom);
      tick();
    end
    chk("rst_pe_en", 32'(pe_en), 32'd0);
    chk("rst_busy", 32'(acc_busy), 32'd0);
    chk("rst_vld", 32'(sum_vld), 32'd0);
    chk("rst_data", 32'(sum_data), 32'd0);
    chk("rst_ovf", 32'(sum_ovf), 32'd0);
    rst_n = 1'b1; acc_start = 1'b0; k_len = '0; prod_vld = 1'b0;
    prod_data = '0; sum_rdy = 1'b1;
    tick();

    // Basic dot-product 3+5+7+9
    pe0 = pe_cycles; vld0 = vld_cycles;
    expect_sum(24, 1'b0);
    start(4);
    chk("pe_en_after_start", 32'(pe_en), 32'd1);
    send(3); send(5); send(7); send(9);
    chk("vld_after_last", 32'(sum_vld), 32'd1);
    chk("pe_en_after_last", 32'(pe_en), 32'd0);
    wait_idle("basic_idle");
    tick();
    chk("basic_pe_cycles", 32'(pe_cycles - pe0), 32'd4);
    chk("basic_vld_cycles", 32'(vld_cycles - vld0), 32'd1);

    // Stalls, ignored starts, backpressure
    sum_rdy = 1'b0;
    expect_sum(600, 1'b0);
    start(3);
    send(100); tick(); start(5); tick();
    send(200); tick(); tick();
    send(300);
    start(1);
    chk("busy_in_done", 32'(acc_busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    sum_rdy = 1'b1;
    wait_idle("stall_idle");
    tick();
    chk("stall_no_restart", 32'(acc_busy), 32'd0);

    // Saturation at 20 bits, then a clean job
    expect_sum(1048575, 1'b1);
    start(17);
    for (int i = 0; i < 17; i++) send(65535);
    wait_idle("sat_idle");
    expect_sum(1, 1'b0);
    start(1); send(1);
    wait_idle("post_sat_idle");

    // Zero length and stray products
    sum_rdy = 1'b0;
    send(50);
    expect_sum(0, 1'b0);
    start(0);
    chk("zero_vld", 32'(sum_vld), 32'd1);
    send(77);
    sum_rdy = 1'b1;
    wait_idle("zero_idle");
    send(40);
    expect_sum(30, 1'b0);
    start(2); send(10); send(20);
    wait_idle("stray_idle");

    // Reset mid-job
    vld0 = vld_cycles;
    start(8); send(1); send(1); send(1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_busy", 32'(acc_busy), 32'd0);
    chk("midrst_pe_en", 32'(pe_en), 32'd0);
    tick();
    chk("midrst_no_vld", 32'(vld_cycles - vld0), 32'd0);
    expect_sum(3, 1'b0);
    start(2); send(1); send(2);
    wait_idle("midrst_idle");
    tick();

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pe_acc.md
# pe_acc

Downstream accumulation stage for one processing element. It consumes the registered 16-bit product stream (`prod_vld`/`prod_data`, driven from the PE result outputs) and sums exactly `k_len` products per job into a saturating accumulator. It drives the PE enable for the job's duration and presents the final dot-product on a valid/ready output port.

## Interface
Parameters:
- `ACC_W`, default 24: accumulator and sum width in bits (≥17).
- `K_W`, default 8: width of the product-count field.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `acc_start`  in  1  job start pulse; accepted only in IDLE.
- `k_len`  in  K_W  number of products in the job; sampled with an accepted `acc_start`.
- `prod_vld`  in  1  product valid, from the PE result valid.
- `prod_data`  in  16  unsigned product, from the PE result data.
- `pe_en`  out  1  enable to the PE; high only in ACC.
- `acc_busy`  out  1  high whenever state ≠ IDLE.
- `sum_vld`  out  1  final sum valid.
- `sum_data`  out  ACC_W  final sum (registered).
- `sum_ovf`  out  1  saturation occurred during this job; qualified by `sum_vld`.
- `sum_rdy`  in  1  consumer accepts the sum.

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - state → IDLE; accumulator, counter and `sum_data` → 0.
  - `sum_vld`, `sum_ovf`, `pe_en` and `acc_busy` → 0.
  - Reset mid-job abandons the job with no output.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `acc_start`=1 and `k_len`≠0: clear the accumulator and `sum_ovf`, load counter = `k_len`, go to ACC.
  - `acc_start`=1 and `k_len`=0: clear the accumulator and `sum_ovf`, go directly to DONE with `sum_data`=0.
  - `prod_vld` is ignored.
- ACC:
  - Each cycle with `prod_vld`=1: acc ← acc + zero-extend(`prod_data`), and the counter decrements.
  - If the true sum exceeds 2^ACC_W−1, acc ← 2^ACC_W−1 and `sum_ovf` is set. The flag stays set for the rest of the job.
  - When the product that takes the counter from 1 to 0 is accepted, go to DONE.
  - `prod_vld`=0 cycles are stalls; no timeout applies.
  - `acc_start` is ignored.
- DONE:
  - `sum_vld`=1; `sum_data` and `sum_ovf` are held stable until `sum_rdy`=1.
  - On `sum_vld`&`sum_rdy`, go to IDLE.
  - `acc_start` and `prod_vld` are ignored, including in the handshake cycle.
- Arithmetic: unsigned only. The adder is ACC_W+1 bits wide; its carry-out is the saturation condition.
- Products arriving outside ACC are dropped silently. Preventing this is the upstream sequencer's responsibility.

## Timing
- `acc_start` accepted at edge t:
  - ACC: `pe_en`=1 and `acc_busy`=1 from t+1.
  - `k_len`=0: `sum_vld`=1 from t+1.
- Last product accepted at edge t: `pe_en`=0 and `sum_vld`=1 from t+1.
- Sum handshake at edge t: `sum_vld`=0 and `acc_busy`=0 from t+1.
  - The earliest next `acc_start` is accepted at edge t+1.
- Minimum job length is `k_len`+2 cycles from start to return to IDLE, with no stalls and `sum_rdy` tied high.
- `pe_en`, `acc_busy`, `sum_vld`, `sum_data` and `sum_ovf` are all register outputs; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with random inputs → all outputs 0 and state IDLE.
- **Basic dot-product:** start with `k_len`=4, then `prod_data`=3, 5, 7, 9 on consecutive cycles; `sum_rdy`=1.
  - `sum_vld` is high for exactly one cycle, one cycle after the 4th product.
  - `sum_data`=24, `sum_ovf`=0, and `pe_en` is high for exactly 4 cycles.
- **Stalls and backpressure:** start with `k_len`=3; products 100, 200, 300 with 2-cycle gaps; `sum_rdy`=0 for 5 cycles, then 1.
  - `sum_data`=600 and is held for the whole wait.
  - `acc_start` pulsed during ACC and DONE is ignored.
- **Saturation:** set `ACC_W`=20, start with `k_len`=17, all `prod_data`=65535.
  - `sum_data`=1048575 and `sum_ovf`=1.
  - The next job (`k_len`=1, product 1) → `sum_data`=1, `sum_ovf`=0.
- **Zero length and stray products:** start with `k_len`=0 → `sum_vld`=1 next cycle with `sum_data`=0.
  - `prod_vld` pulses in IDLE and DONE do not affect the following job (`k_len`=2, products 10, 20 → 30).
- **Reset mid-job:** start with `k_len`=8; assert `rst_n`=0 after 3 products.
  - No `sum_vld` is produced and the block returns to IDLE.
  - A fresh `k_len`=2 job with products 1, 2 gives 3.
